// File: rtl/nibble_serial_sub.sv
// Multi-cycle subtractor: in_a - in_b - bin, one 4-bit nibble per clock, LSB nibble first,
// with the borrow rippled between nibbles through a register. Start/busy/done handshake.
module nibble_serial_sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic             brw_r;
  logic [CW-1:0]    cnt;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       sub_res;
  logic [WIDTH-1:0] diff_nx;
  logic             last;
  logic             accept;

  // Returns {borrow_out, d}; the borrow is the inverted carry of a + ~b + ~borrow_in.
  function automatic logic [4:0] nib_sub(input logic [3:0] a, input logic [3:0] b,
                                         input logic bi);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, ~b} + {4'b0000, ~bi};
    return {~s[4], s[3:0]};
  endfunction

  always_comb begin
    accept  = start && (state != RUN);
    last    = (cnt == CW'(N - 1));
    a_nib   = 4'h0;
    b_nib   = 4'h0;
    diff_nx = diff;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) begin
        a_nib = a_r[i*4 +: 4];
        b_nib = b_r[i*4 +: 4];
      end
    end
    sub_res = nib_sub(a_nib, b_nib, brw_r);
    // Only the nibble at the current position changes; the rest keep their old value.
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) diff_nx[i*4 +: 4] = sub_res[3:0];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      brw_r <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r   <= in_a;
        b_r   <= in_b;
        brw_r <= bin;
        cnt   <= '0;
      end else if (state == RUN) begin
        diff  <= diff_nx;
        brw_r <= sub_res[4];
        cnt   <= cnt + CW'(1);
        // Flags come from the completed word, registered on the final nibble's edge.
        if (last) begin
          bout <= sub_res[4];
          zero <= (diff_nx == '0);
          neg  <= diff_nx[WIDTH-1];
          ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_nx[WIDTH-1] != a_r[WIDTH-1]);
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub: directed plan cases, random operands against
// an arithmetic reference, start-while-busy, back-to-back and mid-run reset scenarios.
module tb_nibble_serial_sub;

  localparam int WIDTH = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             neg;
  logic             ovf;

  int n_cmp;
  int n_err;

  nibble_serial_sub #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .in_a (in_a),
    .in_b (in_b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .zero (zero),
    .neg  (neg),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {diff, bout, zero, neg, ovf} from plain integer arithmetic.
  function automatic logic [WIDTH+3:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b, input logic bi);
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] d;
    logic             bo, z, n, o;
    longint           sd;
    wide = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bi);
    d    = wide[WIDTH-1:0];
    bo   = ({1'b0, a} < ({1'b0, b} + (WIDTH+1)'(bi)));
    z    = (d == '0);
    n    = d[WIDTH-1];
    sd   = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    o    = (sd > SMAX) || (sd < SMIN);
    return {d, bo, z, n, o};
  endfunction

  function automatic logic [WIDTH+3:0] observed();
    return {diff, bout, zero, neg, ovf};
  endfunction

  // Drives one start at the current (post-edge) time and waits for done.
  // lat counts edges with the accepting edge as 1; bcnt counts cycles with busy high.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bi, output int lat, output int bcnt);
    in_a  = a;
    in_b  = b;
    bin   = bi;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_a  = $urandom();
    in_b  = $urandom();
    bin   = 1'($urandom_range(0, 1));
    lat   = 1;
    bcnt  = busy ? 1 : 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_ctrl: busy/done=%b required 00", {busy, done});
    end
    n_cmp++;
    if (observed() !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h required 0", observed());
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] ta [7] = '{32'h00000005, 32'h00000000, 32'h12345678, 32'h80000000,
                                 32'h7FFFFFFF, 32'h00000005, 32'h00010000};
    logic [WIDTH-1:0] tb [7] = '{32'h00000003, 32'h00000001, 32'h12345678, 32'h00000001,
                                 32'hFFFFFFFF, 32'h00000005, 32'h00000000};
    logic             tc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [WIDTH-1:0] td [7] = '{32'h00000002, 32'hFFFFFFFF, 32'h00000000, 32'h7FFFFFFF,
                                 32'h80000000, 32'hFFFFFFFF, 32'h0000FFFF};
    int lat, bcnt;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], tc[i], lat, bcnt);
      n_cmp++;
      if (lat != 9) begin
        n_err++;
        $display("FAIL dir%0d_latency: got %0d edges required 9", i, lat);
      end
      n_cmp++;
      if (bcnt != 8) begin
        n_err++;
        $display("FAIL dir%0d_busy_cycles: got %0d required 8", i, bcnt);
      end
      n_cmp++;
      if (diff !== td[i]) begin
        n_err++;
        $display("FAIL dir%0d_diff: got %h required %h", i, diff, td[i]);
      end
      n_cmp++;
      if (observed() !== model(ta[i], tb[i], tc[i])) begin
        n_err++;
        $display("FAIL dir%0d_result: got %h required %h", i, observed(),
                 model(ta[i], tb[i], tc[i]));
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL dir%0d_done_pulse: done=%b required 0", i, done);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    logic             bi;
    logic [WIDTH+3:0] exp;
    int lat, bcnt;
    for (int i = 0; i < 25; i++) begin
      a  = $urandom();
      b  = (i % 5 == 0) ? a : $urandom();
      bi = 1'($urandom_range(0, 1));
      exp = model(a, b, bi);
      run_op(a, b, bi, lat, bcnt);
      n_cmp++;
      if (lat != 9 || observed() !== exp) begin
        n_err++;
        $display("FAIL rand%0d: got lat=%0d res=%h required lat=9 res=%h", i, lat, observed(), exp);
      end
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      n_cmp++;
      if (observed() !== exp || done !== 1'b0) begin
        n_err++;
        $display("FAIL rand%0d_hold: got res=%h done=%b required res=%h done=0",
                 i, observed(), done, exp);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [WIDTH-1:0] a, b;
    logic [WIDTH+3:0] exp;
    int lat;
    a = 32'hA5A50F0F;
    b = 32'h0123F00F;
    exp = model(a, b, 1'b1);
    in_a  = a;
    in_b  = b;
    bin   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    @(posedge clk); #1;
    lat++;
    for (int c = 2; c <= 5; c++) begin
      start = 1'b1;
      in_a  = $urandom();
      in_b  = $urandom();
      bin   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat != 9) begin
      n_err++;
      $display("FAIL busy_start_latency: got %0d edges required 9", lat);
    end
    n_cmp++;
    if (observed() !== exp) begin
      n_err++;
      $display("FAIL busy_start_result: got %h required %h", observed(), exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a1, b1, a2, b2;
    logic [WIDTH+3:0] e1, e2;
    int lat, bcnt;
    a1 = $urandom(); b1 = $urandom();
    a2 = $urandom(); b2 = $urandom();
    e1 = model(a1, b1, 1'b0);
    e2 = model(a2, b2, 1'b1);
    run_op(a1, b1, 1'b0, lat, bcnt);
    n_cmp++;
    if (lat != 9 || observed() !== e1) begin
      n_err++;
      $display("FAIL b2b_first: got lat=%0d res=%h required lat=9 res=%h", lat, observed(), e1);
    end
    // Start issued while done is high: must be taken with no idle cycle.
    run_op(a2, b2, 1'b1, lat, bcnt);
    n_cmp++;
    if (lat != 9 || bcnt != 8) begin
      n_err++;
      $display("FAIL b2b_timing: got lat=%0d busy=%0d required lat=9 busy=8", lat, bcnt);
    end
    n_cmp++;
    if (observed() !== e2) begin
      n_err++;
      $display("FAIL b2b_second: got %h required %h", observed(), e2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [WIDTH-1:0] a, b;
    int lat, bcnt, dcnt;
    in_a  = 32'hFFFFFFFF;
    in_b  = 32'h00000000;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL midrst_ctrl: busy/done=%b required 00", {busy, done});
    end
    n_cmp++;
    if (observed() !== '0) begin
      n_err++;
      $display("FAIL midrst_data: got %h required 0", observed());
    end
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    n_cmp++;
    if (dcnt != 0) begin
      n_err++;
      $display("FAIL midrst_no_done: got %0d active cycles required 0", dcnt);
    end
    a = $urandom(); b = $urandom();
    run_op(a, b, 1'b0, lat, bcnt);
    n_cmp++;
    if (lat != 9 || observed() !== model(a, b, 1'b0)) begin
      n_err++;
      $display("FAIL midrst_fresh: got lat=%0d res=%h required lat=9 res=%h",
               lat, observed(), model(a, b, 1'b0));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    in_a  = '0;
    in_b  = '0;
    bin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
